// File: rtl/mac4_matvec_seq.sv
`timescale 1ns/1ps
// mac4_matvec_seq
// Sequencer for one mac4 lane computing y = W*x (Q4.12). Each row of W is
// read from the weight RAM one 4-operand word ("chunk") at a time, paired
// with the matching vector word, and fed to an external combinational
// mac4. Per-chunk results are summed in a wide signed accumulator and each
// row is emitted as a saturated Q4.12 value on a valid/ready stream.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         job request, sampled only in IDLE
//   rows_i, cols_i  job shape, latched on start (cols must be a multiple of 4)
//   busy_o          job in progress
//   done_o          one-cycle pulse at job end (also for a rejected job)
//   err_o           last job was rejected; cleared by the next accepted start
//   w_en_o/w_addr_o/w_rdata_i  weight RAM read port (1-cycle latency)
//   x_en_o/x_addr_o/x_rdata_i  vector RAM read port (1-cycle latency)
//   mac_a_o/mac_b_o/mac_result_i  operand lanes to / result from mac4
//   out_valid_o/out_ready_i/out_data_o/out_row_o/out_sat_o  row result stream
module mac4_matvec_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_ROWS   = 64,
  parameter int MAX_COLS   = 64,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [$clog2(MAX_ROWS+1)-1:0]     rows_i,
  input  logic [$clog2(MAX_COLS+1)-1:0]     cols_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic                              w_en_o,
  output logic [ADDR_WIDTH-1:0]             w_addr_o,
  input  logic [4*DATA_WIDTH-1:0]           w_rdata_i,
  output logic                              x_en_o,
  output logic [ADDR_WIDTH-1:0]             x_addr_o,
  input  logic [4*DATA_WIDTH-1:0]           x_rdata_i,
  output logic [4*DATA_WIDTH-1:0]           mac_a_o,
  output logic [4*DATA_WIDTH-1:0]           mac_b_o,
  input  logic [DATA_WIDTH-1:0]             mac_result_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [DATA_WIDTH-1:0]             out_data_o,
  output logic [$clog2(MAX_ROWS)-1:0]       out_row_o,
  output logic                              out_sat_o
);

  localparam int RW  = $clog2(MAX_ROWS+1);
  localparam int CW  = $clog2(MAX_COLS+1);
  localparam int ORW = $clog2(MAX_ROWS);

  localparam logic [RW-1:0] MAX_ROWS_C = RW'(MAX_ROWS);
  localparam logic [CW-1:0] MAX_COLS_C = CW'(MAX_COLS);

  // Q4.12 clip bounds expressed in accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACC, S_EMIT} state_e;

  state_e                        state_q, state_d;
  logic [RW-1:0]                 rows_q, rows_d;
  logic [CW-1:0]                 nchunk_q, nchunk_d;   // cols/4
  logic [RW-1:0]                 row_q, row_d;
  logic [CW-1:0]                 chunk_q, chunk_d;
  logic [ADDR_WIDTH-1:0]         base_q, base_d;       // row*(cols/4), kept incrementally
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic [ORW-1:0]                out_row_q, out_row_d;
  logic                          out_sat_q, out_sat_d;

  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic                          job_bad;
  logic [DATA_WIDTH:0]           sat_res;

  // Returns {clipped, value}.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] r;
    if (a > SAT_MAX)      r = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    else if (a < SAT_MIN) r = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    else                  r = {1'b0, a[DATA_WIDTH-1:0]};
    return r;
  endfunction

  assign acc_sum = acc_q + $signed({{(ACC_WIDTH-DATA_WIDTH){mac_result_i[DATA_WIDTH-1]}}, mac_result_i});
  assign sat_res = saturate(acc_sum);
  assign job_bad = (rows_i == '0) || (cols_i == '0) || (cols_i[1:0] != 2'b00) ||
                   (rows_i > MAX_ROWS_C) || (cols_i > MAX_COLS_C);

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    nchunk_d    = nchunk_q;
    row_d       = row_q;
    chunk_d     = chunk_q;
    base_d      = base_q;
    acc_d       = acc_q;
    done_d      = 1'b0;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_sat_d   = out_sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rows_d   = rows_i;
          nchunk_d = cols_i >> 2;
          if (job_bad) begin
            // Rejected: report and stay idle, busy never rises.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            row_d   = '0;
            chunk_d = '0;
            base_d  = '0;
            acc_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: state_d = S_ACC;

      S_ACC: begin
        acc_d = acc_sum;
        if (chunk_q == nchunk_q - CW'(1)) begin
          // Capture the row result on the way into EMIT so it is held
          // stable for as long as downstream stalls.
          out_valid_d = 1'b1;
          out_row_d   = row_q[ORW-1:0];
          out_sat_d   = sat_res[DATA_WIDTH];
          out_data_d  = sat_res[DATA_WIDTH-1:0];
          state_d     = S_EMIT;
        end else begin
          chunk_d = chunk_q + CW'(1);
          state_d = S_ISSUE;
        end
      end

      S_EMIT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (row_q == rows_q - RW'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d   = row_q + RW'(1);
            chunk_d = '0;
            acc_d   = '0;
            base_d  = base_q + ADDR_WIDTH'(nchunk_q);
            state_d = S_ISSUE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here and has priority over everything else,
  // including a job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      nchunk_q    <= '0;
      row_q       <= '0;
      chunk_q     <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q     <= state_d;
      rows_q      <= rows_d;
      nchunk_q    <= nchunk_d;
      row_q       <= row_d;
      chunk_q     <= chunk_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_sat_q   <= out_sat_d;
    end
  end

  // RAM ports and mac operands are only non-zero in their own state.
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign w_en_o      = (state_q == S_ISSUE);
  assign x_en_o      = (state_q == S_ISSUE);
  assign w_addr_o    = (state_q == S_ISSUE) ? base_q + ADDR_WIDTH'(chunk_q) : '0;
  assign x_addr_o    = (state_q == S_ISSUE) ? ADDR_WIDTH'(chunk_q) : '0;
  assign mac_a_o     = (state_q == S_ACC) ? w_rdata_i : '0;
  assign mac_b_o     = (state_q == S_ACC) ? x_rdata_i : '0;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_row_o   = out_row_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_mac4_matvec_seq.sv
`timescale 1ns/1ps
// Bench for mac4_matvec_seq: behavioural RAMs, a mac4 model (real dot
// product or constant stub) and a scoreboard of expected row results.
module tb_mac4_matvec_seq;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int MR  = 64;
  localparam int MC  = 64;
  localparam int RW  = $clog2(MR+1);
  localparam int CW  = $clog2(MC+1);
  localparam int ORW = $clog2(MR);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start;
  logic [RW-1:0]     rows_in;
  logic [CW-1:0]     cols_in;
  logic              busy, done, err;
  logic              w_en, x_en;
  logic [AW-1:0]     w_addr, x_addr;
  logic [4*DW-1:0]   w_rdata, x_rdata;
  logic [4*DW-1:0]   mac_a, mac_b;
  logic [DW-1:0]     mac_result;
  logic              out_valid, out_ready, out_sat;
  logic [DW-1:0]     out_data;
  logic [ORW-1:0]    out_row;

  mac4_matvec_seq dut (
    .clk(clk), .rst(rst), .start_i(start), .rows_i(rows_in), .cols_i(cols_in),
    .busy_o(busy), .done_o(done), .err_o(err),
    .w_en_o(w_en), .w_addr_o(w_addr), .w_rdata_i(w_rdata),
    .x_en_o(x_en), .x_addr_o(x_addr), .x_rdata_i(x_rdata),
    .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_result_i(mac_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_row_o(out_row), .out_sat_o(out_sat)
  );

  // Synchronous RAMs, one-cycle read latency.
  logic [4*DW-1:0] wmem [0:255];
  logic [4*DW-1:0] xmem [0:63];
  always @(posedge clk) begin
    if (w_en) w_rdata <= wmem[w_addr[7:0]];
    if (x_en) x_rdata <= xmem[x_addr[5:0]];
  end

  // mac4 model: mode 0 = Q4.12 dot product of four lanes, saturated;
  // mode 1 = stub returning a fixed value.
  int            mac_mode;
  logic [DW-1:0] mac_const;

  function automatic logic [DW-1:0] mac_fn(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                                           input int mode, input logic [DW-1:0] k);
    longint s;
    logic [DW-1:0] r;
    s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
    s = s >>> 12;
    if (s > 32767)       r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else                 r = s[15:0];
    if (mode == 1) r = k;
    return r;
  endfunction

  assign mac_result = mac_fn(mac_a, mac_b, mac_mode, mac_const);

  typedef struct packed {
    logic [ORW-1:0] row;
    logic [DW-1:0]  data;
    logic           sat;
  } exp_t;

  exp_t          sb [$];
  logic [AW-1:0] wa_log [$];
  logic [AW-1:0] xa_log [$];
  int            rd_count;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of a whole job: push one expected entry per row.
  task automatic push_expected(input int r, input int c);
    int nc;
    logic signed [31:0] acc;
    logic [DW-1:0] m;
    exp_t e;
    nc = c / 4;
    for (int row = 0; row < r; row++) begin
      acc = 0;
      for (int ch = 0; ch < nc; ch++) begin
        m = mac_fn(wmem[row*nc + ch], xmem[ch], mac_mode, mac_const);
        acc = acc + $signed({{16{m[15]}}, m});
      end
      e.row = ORW'(row);
      if (acc > 32767)       begin e.data = 16'h7FFF; e.sat = 1'b1; end
      else if (acc < -32768) begin e.data = 16'h8000; e.sat = 1'b1; end
      else                   begin e.data = acc[15:0]; e.sat = 1'b0; end
      sb.push_back(e);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    rd_count = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (w_en) begin
          rd_count++;
          wa_log.push_back(w_addr);
          xa_log.push_back(x_addr);
        end
        if (out_valid) check("no_read_in_emit", {62'd0, w_en, x_en}, 64'd0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_row", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("out_row", 64'(out_row), 64'(e.row));
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_sat", 64'(out_sat), 64'(e.sat));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int r, input int c);
    rows_in = RW'(r);
    cols_in = CW'(c);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {57'd0, busy, done, err, w_en, x_en, out_valid, out_sat}, 64'd0);
    check({tag, "_addr"}, {40'd0, w_addr, x_addr}, 64'd0);
    check({tag, "_mac"}, mac_a | mac_b, 64'd0);
    check({tag, "_out"}, {42'd0, out_row, out_data}, 64'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) wmem[i] = {$urandom, $urandom};
    for (int i = 0; i < 64; i++)  xmem[i] = {$urandom, $urandom};
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) wmem[i] = '0;
    for (int i = 0; i < 64; i++)  xmem[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rc;
    int seen;
    logic [DW-1:0]  hold_data;
    logic [ORW-1:0] hold_row;
    int bad_r [5];
    int bad_c [5];

    n_checks  = 0;
    n_errors  = 0;
    start     = 1'b0;
    rows_in   = '0;
    cols_in   = '0;
    out_ready = 1'b1;
    mac_mode  = 0;
    mac_const = '0;
    clear_mems();

    // Reset state.
    repeat (3) tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // 1: real mac, rows=1 cols=8; each lane 0.25*1.0 so each chunk gives 0x1000.
    for (int i = 0; i < 2; i++) begin
      wmem[i] = {4{16'h0400}};
      xmem[i] = {4{16'h1000}};
    end
    wa_log.delete(); xa_log.delete();
    push_expected(1, 8);
    start_job(1, 8);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_busy_emit", 64'(busy), 64'd1);
    tick();
    check("t1_done", {62'd0, done, busy}, {62'd0, 1'b1, 1'b0});
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_nreads", 64'(wa_log.size()), 64'd2);
    for (int i = 0; i < 2 && i < wa_log.size(); i++) begin
      check("t1_w_addr", 64'(wa_log[i]), 64'(i));
      check("t1_x_addr", 64'(xa_log[i]), 64'(i));
    end

    // 2: stub mac, positive and negative saturation over four chunks.
    mac_mode  = 1;
    mac_const = 16'h7000;
    push_expected(1, 16);
    start_job(1, 16);
    wait_done(100);
    mac_const = 16'h9000;
    push_expected(1, 16);
    start_job(1, 16);
    wait_done(100);
    mac_mode = 0;

    // 3: rows=3 cols=4, row r yields r+1; stall 5 cycles on row 1.
    clear_mems();
    for (int r = 0; r < 3; r++) wmem[r] = {48'd0, 16'(r + 1)};
    xmem[0] = {48'd0, 16'h1000};
    wa_log.delete(); xa_log.delete();
    push_expected(3, 4);
    start_job(3, 4);
    lat = 0;
    while (!(out_valid && out_row == 1) && lat < 50) begin
      tick();
      lat++;
    end
    check("t3_row1_seen", {62'd0, out_valid, out_row == 1}, 64'd3);
    out_ready = 1'b0;
    hold_data = out_data;
    hold_row  = out_row;
    rc = rd_count;
    repeat (5) begin
      tick();
      check("t3_stall_data", {22'd0, out_valid, out_row, out_data}, {22'd0, 1'b1, hold_row, hold_data});
    end
    check("t3_stall_reads", 64'(rd_count), 64'(rc));
    out_ready = 1'b1;
    wait_done(50);
    tick();
    check("t3_nreads", 64'(wa_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < wa_log.size(); i++) begin
      check("t3_w_addr", 64'(wa_log[i]), 64'(i));
      check("t3_x_addr", 64'(xa_log[i]), 64'd0);
    end

    // 4: rejected jobs, then a valid job clears err.
    bad_r = '{1, 1, 0, 65, 1};
    bad_c = '{6, 0, 4, 4, 68};
    for (int i = 0; i < 5; i++) begin
      rc = rd_count;
      start_job(bad_r[i], bad_c[i]);
      check("t4_rej", {61'd0, err, done, busy}, {61'd0, 1'b1, 1'b1, 1'b0});
      tick();
      check("t4_after", {61'd0, err, done, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
      check("t4_no_reads", 64'(rd_count), 64'(rc));
    end
    fill_random();
    push_expected(1, 4);
    start_job(1, 4);
    check("t4_err_clear", {62'd0, err, busy}, {62'd0, 1'b0, 1'b1});
    wait_done(50);
    tick();

    // Boundary shapes with random operands: full width, then full height.
    push_expected(4, 64);
    start_job(4, 64);
    wait_done(400);
    tick();
    push_expected(64, 4);
    start_job(64, 4);
    wait_done(400);
    tick();

    // 5: reset during the second ACC of rows=2 cols=8.
    start_job(2, 8);
    seen = 0;
    lat = 0;
    while (lat < 20) begin
      if (w_en) seen++;
      if (seen == 2) break;
      tick();
      lat++;
    end
    check("t5_second_issue", 64'(seen), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    check_quiet("t5_after_rst");
    rst = 1'b0;
    tick();
    check("t5_no_done", {62'd0, done, busy}, 64'd0);
    push_expected(2, 8);
    start_job(2, 8);
    wait_done(100);
    tick();

    // 6: start while busy is ignored; start in the done cycle is accepted.
    push_expected(2, 4);
    start_job(2, 4);
    tick();
    start_job(1, 8);
    wait_done(100);
    check("t6_busy_in_done", 64'(busy), 64'd0);
    push_expected(1, 8);
    start_job(1, 8);
    check("t6_restart_busy", 64'(busy), 64'd1);
    wait_done(100);
    tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
